// File: rtl/id_stage_pipelined.sv
// MIPS instruction-decode stage with register file, load-use hazard detection and ID/EX register.
// Define ID_WB_BYPASS_EN to forward same-cycle write-back data into the latched operands.
module id_stage_pipelined #(
  parameter int DATA_W  = 32,
  parameter int REG_CNT = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [31:0]       if_pc,
  input  logic [31:0]       if_inst,
  input  logic              wb_we,
  input  logic [4:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic              stall,
  output logic              ex_valid,
  output logic [31:0]       ex_pc,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd,
  output logic              ex_alu_src,
  output logic              ex_reg_dst,
  output logic              ex_branch,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_reg_write,
  output logic              ex_mem_to_reg,
  output logic [1:0]        ex_alu_op
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  logic [DATA_W-1:0] rf_q [REG_CNT];

  logic [5:0]        opcode_s;
  logic [4:0]        rs_s, rt_s, rd_s;
  logic [DATA_W-1:0] imm_s, rd1_s, rd2_s;
  logic              alu_src_s, reg_dst_s, branch_s, mem_read_s, mem_write_s;
  logic              reg_write_s, mem_to_reg_s, uses_rt_s, stall_raw_s;
  logic [1:0]        alu_op_s;

  logic              ex_valid_d, ex_valid_q;
  logic [31:0]       ex_pc_d, ex_pc_q;
  logic [DATA_W-1:0] ex_rd1_d, ex_rd1_q, ex_rd2_d, ex_rd2_q, ex_imm_d, ex_imm_q;
  logic [4:0]        ex_rs_d, ex_rs_q, ex_rt_d, ex_rt_q, ex_rd_d, ex_rd_q;
  logic              ex_alu_src_d, ex_alu_src_q, ex_reg_dst_d, ex_reg_dst_q;
  logic              ex_branch_d, ex_branch_q, ex_mem_read_d, ex_mem_read_q;
  logic              ex_mem_write_d, ex_mem_write_q, ex_reg_write_d, ex_reg_write_q;
  logic              ex_mem_to_reg_d, ex_mem_to_reg_q;
  logic [1:0]        ex_alu_op_d, ex_alu_op_q;

  assign opcode_s = if_inst[31:26];
  assign rs_s     = if_inst[25:21];
  assign rt_s     = if_inst[20:16];
  assign rd_s     = if_inst[15:11];
  assign imm_s    = DATA_W'($signed(if_inst[15:0]));

  always_comb begin
    alu_src_s    = 1'b0;
    reg_dst_s    = 1'b0;
    branch_s     = 1'b0;
    mem_read_s   = 1'b0;
    mem_write_s  = 1'b0;
    reg_write_s  = 1'b0;
    mem_to_reg_s = 1'b0;
    alu_op_s     = 2'b00;
    uses_rt_s    = 1'b0;
    case (opcode_s)
      OP_RTYPE: begin
        reg_dst_s   = 1'b1;
        reg_write_s = 1'b1;
        alu_op_s    = 2'b10;
        uses_rt_s   = 1'b1;
      end
      OP_LW: begin
        alu_src_s    = 1'b1;
        mem_read_s   = 1'b1;
        reg_write_s  = 1'b1;
        mem_to_reg_s = 1'b1;
      end
      OP_SW: begin
        alu_src_s   = 1'b1;
        mem_write_s = 1'b1;
        uses_rt_s   = 1'b1;
      end
      OP_BEQ: begin
        branch_s  = 1'b1;
        alu_op_s  = 2'b01;
        uses_rt_s = 1'b1;
      end
      OP_ADDI: begin
        alu_src_s   = 1'b1;
        reg_write_s = 1'b1;
      end
      default: begin
        alu_op_s = 2'b00;
      end
    endcase
  end

  // Entry 0 is never written so it stays at its reset value of zero.
  always_ff @(posedge clk) begin
    for (int i = 0; i < REG_CNT; i++) begin
      if (rst) begin
        rf_q[i] <= {DATA_W{1'b0}};
      end else if (wb_we && (i != 0) && (wb_addr == 5'(i))) begin
        rf_q[i] <= wb_data;
      end
    end
  end

`ifdef ID_WB_BYPASS_EN
  localparam logic [5:0] REG_LIM = 6'(REG_CNT);
  logic wb_fwd_s;
  assign wb_fwd_s = wb_we && (wb_addr != 5'd0) && ({1'b0, wb_addr} < REG_LIM);
`endif

  // Unimplemented addresses and r0 fall through to the zero default.
  always_comb begin
    rd1_s = {DATA_W{1'b0}};
    rd2_s = {DATA_W{1'b0}};
    for (int i = 1; i < REG_CNT; i++) begin
      rd1_s = (rs_s == 5'(i)) ? rf_q[i] : rd1_s;
      rd2_s = (rt_s == 5'(i)) ? rf_q[i] : rd2_s;
    end
`ifdef ID_WB_BYPASS_EN
    rd1_s = (wb_fwd_s && (wb_addr == rs_s)) ? wb_data : rd1_s;
    rd2_s = (wb_fwd_s && (wb_addr == rt_s)) ? wb_data : rd2_s;
`endif
  end

  assign stall_raw_s = if_valid & ex_valid_q & ex_mem_read_q & (ex_rt_q != 5'd0) &
                       ((ex_rt_q == rs_s) | (uses_rt_s & (ex_rt_q == rt_s)));
  assign stall = stall_raw_s & ~flush;

  always_comb begin
    ex_valid_d      = 1'b0;
    ex_pc_d         = 32'd0;
    ex_rd1_d        = {DATA_W{1'b0}};
    ex_rd2_d        = {DATA_W{1'b0}};
    ex_imm_d        = {DATA_W{1'b0}};
    ex_rs_d         = 5'd0;
    ex_rt_d         = 5'd0;
    ex_rd_d         = 5'd0;
    ex_alu_src_d    = 1'b0;
    ex_reg_dst_d    = 1'b0;
    ex_branch_d     = 1'b0;
    ex_mem_read_d   = 1'b0;
    ex_mem_write_d  = 1'b0;
    ex_reg_write_d  = 1'b0;
    ex_mem_to_reg_d = 1'b0;
    ex_alu_op_d     = 2'b00;
    if (flush || stall_raw_s) begin
      ex_valid_d = 1'b0;
    end else begin
      ex_valid_d      = if_valid;
      ex_pc_d         = if_pc;
      ex_rd1_d        = rd1_s;
      ex_rd2_d        = rd2_s;
      ex_imm_d        = imm_s;
      ex_rs_d         = rs_s;
      ex_rt_d         = rt_s;
      ex_rd_d         = rd_s;
      ex_alu_src_d    = if_valid & alu_src_s;
      ex_reg_dst_d    = if_valid & reg_dst_s;
      ex_branch_d     = if_valid & branch_s;
      ex_mem_read_d   = if_valid & mem_read_s;
      ex_mem_write_d  = if_valid & mem_write_s;
      ex_reg_write_d  = if_valid & reg_write_s;
      ex_mem_to_reg_d = if_valid & mem_to_reg_s;
      ex_alu_op_d     = if_valid ? alu_op_s : 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q      <= 1'b0;
      ex_pc_q         <= 32'd0;
      ex_rd1_q        <= {DATA_W{1'b0}};
      ex_rd2_q        <= {DATA_W{1'b0}};
      ex_imm_q        <= {DATA_W{1'b0}};
      ex_rs_q         <= 5'd0;
      ex_rt_q         <= 5'd0;
      ex_rd_q         <= 5'd0;
      ex_alu_src_q    <= 1'b0;
      ex_reg_dst_q    <= 1'b0;
      ex_branch_q     <= 1'b0;
      ex_mem_read_q   <= 1'b0;
      ex_mem_write_q  <= 1'b0;
      ex_reg_write_q  <= 1'b0;
      ex_mem_to_reg_q <= 1'b0;
      ex_alu_op_q     <= 2'b00;
    end else begin
      ex_valid_q      <= ex_valid_d;
      ex_pc_q         <= ex_pc_d;
      ex_rd1_q        <= ex_rd1_d;
      ex_rd2_q        <= ex_rd2_d;
      ex_imm_q        <= ex_imm_d;
      ex_rs_q         <= ex_rs_d;
      ex_rt_q         <= ex_rt_d;
      ex_rd_q         <= ex_rd_d;
      ex_alu_src_q    <= ex_alu_src_d;
      ex_reg_dst_q    <= ex_reg_dst_d;
      ex_branch_q     <= ex_branch_d;
      ex_mem_read_q   <= ex_mem_read_d;
      ex_mem_write_q  <= ex_mem_write_d;
      ex_reg_write_q  <= ex_reg_write_d;
      ex_mem_to_reg_q <= ex_mem_to_reg_d;
      ex_alu_op_q     <= ex_alu_op_d;
    end
  end

  assign ex_valid      = ex_valid_q;
  assign ex_pc         = ex_pc_q;
  assign ex_rd1        = ex_rd1_q;
  assign ex_rd2        = ex_rd2_q;
  assign ex_imm        = ex_imm_q;
  assign ex_rs         = ex_rs_q;
  assign ex_rt         = ex_rt_q;
  assign ex_rd         = ex_rd_q;
  assign ex_alu_src    = ex_alu_src_q;
  assign ex_reg_dst    = ex_reg_dst_q;
  assign ex_branch     = ex_branch_q;
  assign ex_mem_read   = ex_mem_read_q;
  assign ex_mem_write  = ex_mem_write_q;
  assign ex_reg_write  = ex_reg_write_q;
  assign ex_mem_to_reg = ex_mem_to_reg_q;
  assign ex_alu_op     = ex_alu_op_q;

endmodule

// File: tb/tb_id_stage_pipelined.sv
// Self-checking bench for id_stage_pipelined: directed scenarios plus randomized traffic
// checked against a table-driven reference model (honours ID_WB_BYPASS_EN).
module tb_id_stage_pipelined;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [6:0]  ctrl;   // alu_src, reg_dst, branch, mem_read, mem_write, reg_write, mem_to_reg
    logic [1:0]  alu_op;
  } ex_t;

  logic        clk, rst, if_valid, wb_we, flush, stall;
  logic [31:0] if_pc, if_inst, wb_data;
  logic [4:0]  wb_addr;
  logic        ex_valid, ex_alu_src, ex_reg_dst, ex_branch, ex_mem_read;
  logic        ex_mem_write, ex_reg_write, ex_mem_to_reg;
  logic [31:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [1:0]  ex_alu_op;

  ex_t         dut_b;
  ex_t         m;
  logic [31:0] regs_m [32];
  int          pass_cnt;
  int          total_cnt;

  id_stage_pipelined #(.DATA_W(32), .REG_CNT(32)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush), .stall(stall),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_alu_src(ex_alu_src),
    .ex_reg_dst(ex_reg_dst), .ex_branch(ex_branch), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_alu_op(ex_alu_op)
  );

  assign dut_b = {ex_valid, ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd,
                  ex_alu_src, ex_reg_dst, ex_branch, ex_mem_read, ex_mem_write,
                  ex_reg_write, ex_mem_to_reg, ex_alu_op};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control table: {ctrl[6:0], alu_op[1:0]}
  function automatic logic [8:0] dec_m(input logic [5:0] op);
    case (op)
      6'b000000: return {7'b0100010, 2'b10};
      6'b100011: return {7'b1001011, 2'b00};
      6'b101011: return {7'b1000100, 2'b00};
      6'b000100: return {7'b0010000, 2'b01};
      6'b001000: return {7'b1000010, 2'b00};
      default:   return 9'd0;
    endcase
  endfunction

  function automatic logic uses_rt_m(input logic [5:0] op);
    return (op == 6'b000000) || (op == 6'b101011) || (op == 6'b000100);
  endfunction

  function automatic logic [31:0] rd_m(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
`ifdef ID_WB_BYPASS_EN
    if (wb_we && wb_addr == a) return wb_data;
`endif
    return regs_m[a];
  endfunction

  function automatic logic stall_raw_m();
    logic [4:0] rs, rt;
    rs = if_inst[25:21];
    rt = if_inst[20:16];
    return if_valid && m.valid && m.ctrl[3] && (m.rt != 5'd0) &&
           ((m.rt == rs) || (uses_rt_m(if_inst[31:26]) && m.rt == rt));
  endfunction

  task automatic set_in(input logic v, input logic [31:0] inst, input logic we,
                        input logic [4:0] wa, input logic [31:0] wd, input logic fl);
    if_valid = v;
    if_pc    = if_pc + 32'd4;
    if_inst  = inst;
    wb_we    = we;
    wb_addr  = wa;
    wb_data  = wd;
    flush    = fl;
  endtask

  // Advance one clock: predict the ID/EX contents and register-file effect, then clock.
  task automatic tick();
    ex_t n;
    logic [8:0] d;
    n = '0;
    if (rst) begin
      for (int i = 0; i < 32; i++) regs_m[i] = 32'd0;
    end else begin
      if (!(flush || stall_raw_m())) begin
        d       = dec_m(if_inst[31:26]);
        n.valid = if_valid;
        n.pc    = if_pc;
        n.rd1   = rd_m(if_inst[25:21]);
        n.rd2   = rd_m(if_inst[20:16]);
        n.imm   = {{16{if_inst[15]}}, if_inst[15:0]};
        n.rs    = if_inst[25:21];
        n.rt    = if_inst[20:16];
        n.rd    = if_inst[15:11];
        n.ctrl  = if_valid ? d[8:2] : 7'd0;
        n.alu_op = if_valid ? d[1:0] : 2'd0;
      end
      if (wb_we && wb_addr != 5'd0) regs_m[wb_addr] = wb_data;
    end
    @(posedge clk);
    #1;
    m = n;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      set_in(1'b1, $urandom, 1'b1, 5'($urandom), $urandom, 1'b0);
      tick();
    end
    total_cnt++;
    if (dut_b !== '0) $display("FAIL reset_ex got=%h exp=0", dut_b); else pass_cnt++;
    total_cnt++;
    if (stall !== 1'b0) $display("FAIL reset_stall got=%b exp=0", stall); else pass_cnt++;
    rst = 1'b0;
    for (int i = 1; i < 32; i++) begin
      set_in(1'b1, {6'b000000, 5'(i), 5'(i), 5'd1, 11'h020}, 1'b0, 5'd0, 32'd0, 1'b0);
      tick();
      total_cnt++;
      if ({ex_rd1, ex_rd2} !== 64'd0)
        $display("FAIL reset_reg r%0d got=%h exp=0", i, {ex_rd1, ex_rd2});
      else pass_cnt++;
    end
  endtask

  task automatic test_decode();
    set_in(1'b0, 32'd0, 1'b1, 5'd2, 32'd5, 1'b0);
    tick();
    set_in(1'b0, 32'd0, 1'b1, 5'd3, 32'd7, 1'b0);
    tick();
    set_in(1'b1, 32'h00430820, 1'b0, 5'd0, 32'd0, 1'b0);
    tick();
    total_cnt++;
    if ({ex_rd1, ex_rd2} !== {32'd5, 32'd7})
      $display("FAIL add_operands got=%h exp=%h", {ex_rd1, ex_rd2}, {32'd5, 32'd7});
    else pass_cnt++;
    total_cnt++;
    if ({ex_valid, ex_rd, ex_reg_dst, ex_reg_write, ex_alu_op, ex_alu_src, ex_mem_read} !==
        {1'b1, 5'd1, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0})
      $display("FAIL add_ctrl got=%b exp=%b",
               {ex_valid, ex_rd, ex_reg_dst, ex_reg_write, ex_alu_op, ex_alu_src, ex_mem_read},
               {1'b1, 5'd1, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0});
    else pass_cnt++;
    total_cnt++;
    if (dut_b !== m) $display("FAIL add_model got=%h exp=%h", dut_b, m); else pass_cnt++;
  endtask

  task automatic test_sign_ext();
    set_in(1'b1, 32'h2004FFFF, 1'b0, 5'd0, 32'd0, 1'b0);
    tick();
    total_cnt++;
    if ({ex_imm, ex_alu_src, ex_rd1} !== {32'hFFFFFFFF, 1'b1, 32'd0})
      $display("FAIL addi_imm got=%h exp=%h", {ex_imm, ex_alu_src, ex_rd1},
               {32'hFFFFFFFF, 1'b1, 32'd0});
    else pass_cnt++;
  endtask

  task automatic test_load_use();
    set_in(1'b1, 32'h8C050000, 1'b0, 5'd0, 32'd0, 1'b0);
    #1;
    total_cnt++;
    if (stall !== 1'b0) $display("FAIL lu_lw_stall got=%b exp=0", stall); else pass_cnt++;
    tick();
    set_in(1'b1, 32'h00A53020, 1'b0, 5'd0, 32'd0, 1'b0);
    #1;
    total_cnt++;
    if (stall !== 1'b1) $display("FAIL lu_stall got=%b exp=1", stall); else pass_cnt++;
    tick();
    total_cnt++;
    if ({ex_valid, ex_alu_src, ex_reg_dst, ex_branch, ex_mem_read, ex_mem_write,
         ex_reg_write, ex_mem_to_reg, ex_alu_op} !== 10'd0)
      $display("FAIL lu_bubble got=%h exp=0", dut_b);
    else pass_cnt++;
    #1;
    total_cnt++;
    if (stall !== 1'b0) $display("FAIL lu_release got=%b exp=0", stall); else pass_cnt++;
    tick();
    total_cnt++;
    if ({ex_valid, ex_rs, ex_rt, ex_rd, ex_reg_write} !== {1'b1, 5'd5, 5'd5, 5'd6, 1'b1})
      $display("FAIL lu_issue got=%b exp=%b", {ex_valid, ex_rs, ex_rt, ex_rd, ex_reg_write},
               {1'b1, 5'd5, 5'd5, 5'd6, 1'b1});
    else pass_cnt++;
  endtask

  task automatic test_flush();
    set_in(1'b1, 32'h8C050000, 1'b0, 5'd0, 32'd0, 1'b0);
    tick();
    set_in(1'b1, 32'h00A53020, 1'b0, 5'd0, 32'd0, 1'b1);
    #1;
    total_cnt++;
    if (stall !== 1'b0) $display("FAIL flush_stall got=%b exp=0", stall); else pass_cnt++;
    tick();
    total_cnt++;
    if (dut_b !== '0) $display("FAIL flush_bubble got=%h exp=0", dut_b); else pass_cnt++;
    flush = 1'b0;
  endtask

  task automatic test_bypass();
    logic [31:0] exp_rd1;
`ifdef ID_WB_BYPASS_EN
    exp_rd1 = 32'h000000A5;
`else
    exp_rd1 = regs_m[2];
`endif
    set_in(1'b1, 32'h00430820, 1'b1, 5'd2, 32'h000000A5, 1'b0);
    tick();
    total_cnt++;
    if (ex_rd1 !== exp_rd1) $display("FAIL bypass_same got=%h exp=%h", ex_rd1, exp_rd1);
    else pass_cnt++;
    set_in(1'b1, 32'h00430820, 1'b0, 5'd0, 32'd0, 1'b0);
    tick();
    total_cnt++;
    if (ex_rd1 !== 32'h000000A5) $display("FAIL bypass_after got=%h exp=000000a5", ex_rd1);
    else pass_cnt++;
    set_in(1'b1, 32'h00030820, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0);
    tick();
    total_cnt++;
    if (ex_rd1 !== 32'd0) $display("FAIL r0_same got=%h exp=0", ex_rd1); else pass_cnt++;
    set_in(1'b1, 32'h00030820, 1'b0, 5'd0, 32'd0, 1'b0);
    tick();
    total_cnt++;
    if (ex_rd1 !== 32'd0) $display("FAIL r0_after got=%h exp=0", ex_rd1); else pass_cnt++;
  endtask

  task automatic test_random();
    logic [5:0] ops [6];
    logic [5:0] op;
    logic       exp_stall;
    ops[0] = 6'b000000; ops[1] = 6'b100011; ops[2] = 6'b101011;
    ops[3] = 6'b000100; ops[4] = 6'b001000; ops[5] = 6'b001101;
    for (int c = 0; c < 400; c++) begin
      op = ops[$urandom_range(0, 5)];
      set_in($urandom_range(0, 9) < 8,
             {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)},
             $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
             $urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 49) == 0);
      #1;
      exp_stall = stall_raw_m() && !flush;
      total_cnt++;
      if (stall !== exp_stall) $display("FAIL rnd_stall c=%0d got=%b exp=%b", c, stall, exp_stall);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (dut_b !== m) $display("FAIL rnd_ex c=%0d got=%h exp=%h", c, dut_b, m);
      else pass_cnt++;
    end
    rst = 1'b0;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    m         = '0;
    for (int i = 0; i < 32; i++) regs_m[i] = 32'd0;
    rst = 1'b1;
    if_pc = 32'h00400000;
    set_in(1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    test_reset();
    test_decode();
    test_sign_ext();
    test_load_use();
    test_flush();
    test_bypass();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/id_stage_pipelined.md
# id_stage_pipelined

Parametrised instruction-decode stage with an integrated ID/EX pipeline register for the 5-stage MIPS core. It decodes the IF/ID instruction, reads a parametrised register file with optional write-back bypass, and sign-extends the immediate. It detects load-use hazards and inserts bubbles on stall or flush. It sits between the IF/ID register and the EX stage and replaces the earlier combinational decode path.

## Interface
- DATA_W, 32, register/datapath width (≥16); immediate sign-extended to DATA_W
- REG_CNT, 32, implemented registers (8..32); addresses ≥ REG_CNT read 0, writes ignored
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- if_valid  in  1  IF/ID holds a real instruction
- if_pc  in  32  PC of IF/ID instruction
- if_inst  in  32  IF/ID instruction
- wb_we  in  1  write-back enable
- wb_addr  in  5  write-back register
- wb_data  in  DATA_W  write-back data
- flush  in  1  squash instruction in ID (taken branch from EX)
- stall  out  1  combinational; IF and PC must hold when high
- ex_valid  out  1  ID/EX holds a real instruction
- ex_pc  out  32  registered PC
- ex_rd1, ex_rd2  out  DATA_W  registered operands (rs, rt)
- ex_imm  out  DATA_W  registered sign-extended inst[15:0]
- ex_rs, ex_rt, ex_rd  out  5  registered inst[25:21], [20:16], [15:11]
- ex_alu_src, ex_reg_dst, ex_branch, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg  out  1  registered controls
- ex_alu_op  out  2  registered ALU op class

## Operation
- Decode on inst[31:26]:
  - 000000 R-type: reg_dst=1, reg_write=1, alu_op=10.
  - 100011 lw: alu_src=1, mem_read=1, reg_write=1, mem_to_reg=1, alu_op=00.
  - 101011 sw: alu_src=1, mem_write=1, alu_op=00.
  - 000100 beq: branch=1, alu_op=01.
  - 001000 addi: alu_src=1, reg_write=1, alu_op=00.
  - Any other opcode: all controls 0; ex_valid still follows if_valid.
- uses_rt = R-type | sw | beq.
- Register file: REG_CNT×DATA_W array. r0 always reads 0; writes to r0 are dropped. Written on clk edge when wb_we=1. All entries are cleared on rst.
- Hazard: stall = if_valid & ex_valid & ex_mem_read & (ex_rt≠0) & (ex_rt==rs | (uses_rt & ex_rt==rt)).
- ID/EX update every cycle, in priority order:
  1. rst: all outputs cleared.
  2. flush: bubble loaded.
  3. stall: bubble loaded.
  4. Otherwise: decoded fields loaded, ex_valid=if_valid; when if_valid=0 all controls are forced to 0.
- Bubble = ex_valid=0 and all control outputs 0; data fields are don't-care but are driven to 0.
- flush suppresses stall: stall output is forced to 0 when flush=1.

## Timing
- Latency 1 cycle: if_inst at edge N appears on ex_* after edge N.
- stall is combinational from if_inst, if_valid and the ex_* registers; no clock delay.
- A load-use pair produces exactly one bubble. The next cycle ex_mem_read=0, so stall drops and the held instruction proceeds.
- Reset: every output is 0 after the first clk edge with rst=1, including stall (ex_valid=0). Reset mid-stall discards the held state.
- wb write and a same-cycle read of the same address: see Configuration.

## Configuration
- ID_WB_BYPASS_EN defined: when wb_we=1, wb_addr==rs (or rt), wb_addr≠0 and wb_addr<REG_CNT, the operand latched into ex_rd1/ex_rd2 is wb_data in the same cycle (write-through).
- Undefined: operands come only from the array, so a same-cycle read returns the old value. The core must then add a write-back forward in EX.

## Test plan
- Reset: rst=1 for 2 cycles with arbitrary inputs -> all ex_* = 0, stall = 0; r1..r31 read 0 afterwards.
- Decode and latency: write r2=5, r3=7; issue add r1,r2,r3 (0x00430820) -> next cycle ex_rd1=5, ex_rd2=7, ex_rd=1, reg_dst=1, reg_write=1, alu_op=10, ex_valid=1.
- Sign extension: addi r4,r0,-1 (0x2004FFFF) -> ex_imm = all ones in DATA_W bits, alu_src=1, ex_rd1=0.
- Load-use: lw r5,0(r0) followed by add r6,r5,r5 -> stall=1 for exactly one cycle, one bubble (ex_valid=0, controls 0), add issued on the following cycle.
- Flush priority: flush=1 while stall condition true -> stall=0, bubble loaded.
- Bypass: wb_we=1, wb_addr=2, wb_data=0xA5 concurrent with a read of r2 -> ex_rd1=0xA5 with ID_WB_BYPASS_EN defined; the old value without it. A write to r0 -> r0 still reads 0.
